key_conditioner: RTL and testbench

- Front-end conditioning for the range-hood control state machine.
- Synchronises and debounces the enable switch and the five keys (in1..in5), then converts key presses into one-hot key events.
- Each event is held long enough for the downstream slow-clock (clk_bps) sampler to catch it.
- Output vector {enable_db, key_evt} feeds the state machine's 6-bit input decode directly.

---
 rtl/key_conditioner.sv | 196 +++++++++++++++++++
 tb/tb_key_conditioner.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// Key/enable front end for the range-hood controller: 2-flop sync, per-input debounce,
// press detect and a held one-hot event stream. Optional long-press pulse: KEY_LONG_PRESS_EN.
module key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int PULSE_CYCLES    = 50_000_000,
    parameter int GAP_CYCLES      = 50_000_000
`ifdef KEY_LONG_PRESS_EN
    ,
    parameter int LONG_CYCLES     = 100_000_000
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable_raw,
    input  logic [4:0] keys_raw,
    output logic       enable_db,
    output logic [4:0] key_evt,
    output logic       evt_busy,
    output logic       evt_dropped
`ifdef KEY_LONG_PRESS_EN
    ,
    output logic       long_evt
`endif
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PW = $clog2(PULSE_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int CW = (PW > GW) ? PW : GW;

    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EMIT = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    // Bit 5 carries the enable switch, bits 4:0 the keys (bit4 = in1).
    logic [5:0]    sync1_q, sync1_d;
    logic [5:0]    sync2_q, sync2_d;
    logic [5:0]    db_q, db_d;
    logic [DW-1:0] db_cnt_q [6];
    logic [DW-1:0] db_cnt_d [6];
    logic [4:0]    press_q, press_d;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] phase_cnt_q, phase_cnt_d;
    logic [4:0]    key_evt_q, key_evt_d;

    logic [4:0]    press_sel;
    logic          press_multi;
    logic          dropped;

    always_comb begin
        sync1_d = {enable_raw, keys_raw};
        sync2_d = sync1_q;
    end

    // A level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        for (int i = 0; i < 6; i++) begin
            db_d[i]     = db_q[i];
            db_cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    db_d[i]     = ~db_q[i];
                    db_cnt_d[i] = '0;
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
        press_d = db_d[4:0] & ~db_q[4:0];
    end

    always_comb begin
        press_sel = '0;
        for (int i = 0; i < 5; i++) begin
            if (press_q[i]) begin
                press_sel    = '0;
                press_sel[i] = 1'b1;
            end
        end
        press_multi = |(press_q & ~press_sel);
    end

    always_comb begin
        state_d     = state_q;
        phase_cnt_d = phase_cnt_q;
        key_evt_d   = key_evt_q;
        case (state_q)
            ST_IDLE: begin
                if ((|press_q) && db_q[5]) begin
                    key_evt_d   = press_sel;
                    phase_cnt_d = '0;
                    state_d     = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (phase_cnt_q == PULSE_LAST) begin
                    key_evt_d   = '0;
                    phase_cnt_d = '0;
                    state_d     = ST_GAP;
                end else begin
                    phase_cnt_d = phase_cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (phase_cnt_q == GAP_LAST) begin
                    phase_cnt_d = '0;
                    state_d     = ST_IDLE;
                end else begin
                    phase_cnt_d = phase_cnt_q + 1'b1;
                end
            end
            default: begin
                key_evt_d   = '0;
                phase_cnt_d = '0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // Any lost press in this cycle collapses into one drop pulse.
    always_comb begin
        dropped = (|press_q) && ((state_q != ST_IDLE) || !db_q[5] || press_multi);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            db_q        <= '0;
            press_q     <= '0;
            state_q     <= ST_IDLE;
            phase_cnt_q <= '0;
            key_evt_q   <= '0;
            for (int i = 0; i < 6; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            db_q        <= db_d;
            press_q     <= press_d;
            state_q     <= state_d;
            phase_cnt_q <= phase_cnt_d;
            key_evt_q   <= key_evt_d;
            for (int i = 0; i < 6; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

`ifdef KEY_LONG_PRESS_EN
    localparam int LW = $clog2(LONG_CYCLES + 1);
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);
    localparam logic [LW-1:0] LONG_FULL = LW'(LONG_CYCLES);

    logic [LW-1:0] long_cnt_q, long_cnt_d;
    logic          long_evt_q, long_evt_d;

    // Counter parks at LONG_CYCLES so one hold yields exactly one pulse.
    always_comb begin
        long_cnt_d = long_cnt_q;
        long_evt_d = 1'b0;
        if (!(db_q[4] && db_q[5])) begin
            long_cnt_d = '0;
        end else if (long_cnt_q == LONG_LAST) begin
            long_cnt_d = LONG_FULL;
            long_evt_d = 1'b1;
        end else if (long_cnt_q != LONG_FULL) begin
            long_cnt_d = long_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            long_cnt_q <= '0;
            long_evt_q <= 1'b0;
        end else begin
            long_cnt_q <= long_cnt_d;
            long_evt_q <= long_evt_d;
        end
    end

    assign long_evt = long_evt_q;
`endif

    assign enable_db   = db_q[5];
    assign key_evt     = key_evt_q;
    assign evt_busy    = (state_q != ST_IDLE);
    assign evt_dropped = dropped;

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: directed scenarios plus random key/enable traffic,
// checked every cycle against a timeline model of sync, debounce and event windows.
module tb_key_conditioner;

    localparam int D = 4;
    localparam int P = 3;
    localparam int G = 2;
`ifdef KEY_LONG_PRESS_EN
    localparam int L = 10;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       enable_raw;
    logic [4:0] keys_raw;
    logic       enable_db;
    logic [4:0] key_evt;
    logic       evt_busy;
    logic       evt_dropped;
`ifdef KEY_LONG_PRESS_EN
    logic       long_evt;
`endif

    key_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .PULSE_CYCLES(P),
        .GAP_CYCLES(G)
`ifdef KEY_LONG_PRESS_EN
        ,
        .LONG_CYCLES(L)
`endif
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable_raw(enable_raw),
        .keys_raw(keys_raw),
        .enable_db(enable_db),
        .key_evt(key_evt),
        .evt_busy(evt_busy),
        .evt_dropped(evt_dropped)
`ifdef KEY_LONG_PRESS_EN
        ,
        .long_evt(long_evt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int check_cnt = 0;

    // Reference model: n is the index of the most recent rising edge.
    int         n = 0;
    logic [5:0] s1_m = '0;
    logic [5:0] sync_hist[$];
    logic [5:0] db_m = '0;
    logic [4:0] press_m = '0;
    logic [4:0] evt_val = '0;
    int         evt_end = -1;
    int         busy_end = -1;
`ifdef KEY_LONG_PRESS_EN
    int         lstreak = 0;
    logic       exp_long = 1'b0;
`endif

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        check_cnt++;
        assert (obs === exp_v) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h edge=%0d", tag, obs, exp_v, n);
        end
    endtask

    function automatic logic [4:0] top_key(input logic [4:0] p);
        logic [4:0] r;
        r = '0;
        for (int i = 4; i >= 0; i--) begin
            if (p[i] && r == '0) r[i] = 1'b1;
        end
        return r;
    endfunction

    task automatic model_edge(input logic rst_v, input logic [5:0] in_v);
        logic [5:0] db_old;
        n++;
        if (!rst_v) begin
            s1_m = '0;
            sync_hist.delete();
            for (int j = 0; j < D; j++) sync_hist.push_back('0);
            db_m     = '0;
            press_m  = '0;
            evt_end  = -1;
            busy_end = -1;
`ifdef KEY_LONG_PRESS_EN
            lstreak  = 0;
            exp_long = 1'b0;
`endif
        end else begin
            db_old = db_m;
            // A press visible during cycle n-1 is taken at edge n if idle and enabled.
            if (press_m != '0 && db_old[5] && (n - 1) > busy_end) begin
                evt_val  = top_key(press_m);
                evt_end  = n + P - 1;
                busy_end = n + P + G - 1;
            end
`ifdef KEY_LONG_PRESS_EN
            if (db_old[4] && db_old[5]) lstreak++;
            else lstreak = 0;
            exp_long = (lstreak == L);
`endif
            // New level accepted once the last D synced samples all disagree with it.
            for (int i = 0; i < 6; i++) begin
                bit all_diff;
                all_diff = 1'b1;
                foreach (sync_hist[j]) if (sync_hist[j][i] == db_old[i]) all_diff = 1'b0;
                if (all_diff) db_m[i] = ~db_old[i];
            end
            press_m = db_m[4:0] & ~db_old[4:0];
            sync_hist.push_back(s1_m);
            void'(sync_hist.pop_front());
            s1_m = in_v;
        end
    endtask

    task automatic tick();
        logic       rst_v;
        logic [5:0] in_v;
        logic [4:0] exp_key;
        logic       exp_busy;
        logic       exp_drop;
        @(posedge clk);
        rst_v = reset;
        in_v  = {enable_raw, keys_raw};
        model_edge(rst_v, in_v);
        #1;
        exp_key  = (n <= evt_end) ? evt_val : 5'd0;
        exp_busy = (n <= busy_end);
        exp_drop = (press_m != '0) &&
                   ((n <= busy_end) || !db_m[5] || ($countones(press_m) > 1));
        check("enable_db", {7'd0, enable_db}, {7'd0, db_m[5]});
        check("key_evt", {3'd0, key_evt}, {3'd0, exp_key});
        check("evt_busy", {7'd0, evt_busy}, {7'd0, exp_busy});
        check("evt_dropped", {7'd0, evt_dropped}, {7'd0, exp_drop});
`ifdef KEY_LONG_PRESS_EN
        check("long_evt", {7'd0, long_evt}, {7'd0, exp_long});
`endif
    endtask

    task automatic ticks(input int cnt);
        for (int i = 0; i < cnt; i++) tick();
    endtask

    initial begin
        int k_drops;
        int k_evts;
        int k_any;
        bit found;

        // Reset held with every raw input high.
        reset      = 1'b0;
        enable_raw = 1'b1;
        keys_raw   = 5'h1f;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_outputs", {2'd0, enable_db, key_evt}, 8'd0);
        end
        reset      = 1'b1;
        enable_raw = 1'b0;
        keys_raw   = '0;
        ticks(8);

        // Single in1 press with exact latency and window.
        enable_raw = 1'b1;
        ticks(10);
        keys_raw = 5'b10000;
        for (int j = 1; j <= 14; j++) begin
            tick();
            check("in1_window", {3'd0, key_evt}, (j >= 7 && j <= 9) ? 8'h10 : 8'h00);
            check("in1_busy", {7'd0, evt_busy}, (j >= 7 && j <= 11) ? 8'd1 : 8'd0);
            if (j == 7) check("in1_vector", {2'd0, enable_db, key_evt}, 8'h30);
        end
        keys_raw = '0;
        ticks(10);

        // Glitch shorter than the debounce window.
        keys_raw = 5'b01000;
        ticks(3);
        keys_raw = '0;
        k_any = 0;
        for (int j = 0; j < 12; j++) begin
            tick();
            if (key_evt != '0 || evt_dropped) k_any++;
        end
        check("glitch_silent", 8'(k_any), 8'd0);

        // Simultaneous in2 + in4: in2 wins, one drop.
        keys_raw = 5'b01010;
        k_evts  = 0;
        k_drops = 0;
        for (int j = 0; j < 14; j++) begin
            tick();
            if (key_evt == 5'b01000) k_evts++;
            if (evt_dropped) k_drops++;
        end
        check("simul_evt_cycles", 8'(k_evts), 8'd3);
        check("simul_drops", 8'(k_drops), 8'd1);
        keys_raw = '0;
        ticks(10);

        // Press while disabled.
        enable_raw = 1'b0;
        ticks(10);
        keys_raw = 5'b00001;
        k_evts  = 0;
        k_drops = 0;
        for (int j = 0; j < 12; j++) begin
            tick();
            if (key_evt != '0) k_evts++;
            if (evt_dropped) k_drops++;
        end
        check("disabled_evts", 8'(k_evts), 8'd0);
        check("disabled_drops", 8'(k_drops), 8'd1);
        keys_raw   = '0;
        enable_raw = 1'b1;
        ticks(10);

        // Reset in the second EMIT cycle.
        keys_raw = 5'b00100;
        found = 1'b0;
        for (int j = 0; j < 20 && !found; j++) begin
            tick();
            if (evt_end == n + P - 1) found = 1'b1;
        end
        check("emit_reached", {7'd0, found}, 8'd1);
        tick();
        reset = 1'b0;
        tick();
        check("reset_mid_key", {3'd0, key_evt}, 8'd0);
        check("reset_mid_busy", {7'd0, evt_busy}, 8'd0);
        reset = 1'b1;
        ticks(16);
        keys_raw = '0;
        ticks(10);

`ifdef KEY_LONG_PRESS_EN
        keys_raw = 5'b10000;
        k_any = 0;
        for (int j = 0; j < 30; j++) begin
            tick();
            if (long_evt) k_any++;
        end
        check("long_pulses", 8'(k_any), 8'd1);
        keys_raw = '0;
        ticks(10);
`endif

        // Random traffic: short and long holds, occasional enable flips and resets.
        for (int it = 0; it < 300; it++) begin
            case ($urandom_range(0, 3))
                0: keys_raw = '0;
                1: keys_raw = 5'b00001 << $urandom_range(0, 4);
                default: keys_raw = 5'($urandom_range(0, 31));
            endcase
            if ($urandom_range(0, 9) == 0) enable_raw = ~enable_raw;
            if ($urandom_range(0, 59) == 0) begin
                reset = 1'b0;
                tick();
                reset = 1'b1;
            end
            ticks($urandom_range(1, 7));
        end
        keys_raw = '0;
        ticks(12);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
